// File: rtl/prince_scheduler_if.sv
// rtl/prince_scheduler_if.sv - request, core and response bundle for prince_scheduler
interface prince_scheduler_if;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [127:0] req_s1;
    logic [127:0] req_s2;
    logic [255:0] req_key;
    logic [1:0]   req_enc_dec;

    logic         core_rst;
    logic [63:0]  core_s1;
    logic [63:0]  core_s2;
    logic [127:0] core_key;
    logic         core_enc_dec;
    logic [63:0]  core_out_s1;
    logic [63:0]  core_out_s2;
    logic         core_done;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [63:0]  rsp_s1;
    logic [63:0]  rsp_s2;
    logic         rsp_id;
    logic         rsp_err;

    modport slave (
        input  req_valid, req_s1, req_s2, req_key, req_enc_dec,
        input  core_out_s1, core_out_s2, core_done, rsp_ready,
        output req_ready, core_rst, core_s1, core_s2, core_key, core_enc_dec,
        output rsp_valid, rsp_s1, rsp_s2, rsp_id, rsp_err
    );

    modport master (
        output req_valid, req_s1, req_s2, req_key, req_enc_dec,
        output core_out_s1, core_out_s2, core_done, rsp_ready,
        input  req_ready, core_rst, core_s1, core_s2, core_key, core_enc_dec,
        input  rsp_valid, rsp_s1, rsp_s2, rsp_id, rsp_err
    );
endinterface

// File: rtl/prince_scheduler.sv
// rtl/prince_scheduler.sv - two-requester round-robin job scheduler for a masked PRINCE core
module prince_scheduler #(
    parameter int LOAD_CYCLES = 2,
    parameter int TIMEOUT     = 63
) (
    input  logic              clk,
    input  logic              rst,
    prince_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_t;

    localparam logic [31:0] LOAD_LAST = 32'(LOAD_CYCLES - 1);
    localparam logic [31:0] RUN_LAST  = 32'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [31:0]   cnt_q;
    logic          last_grant_q;
    logic          grant;
    logic          take;
    logic          done_ok;
    logic          timed_out;

    logic [63:0]   cap_s1_q, cap_s2_q;
    logic [127:0]  cap_key_q;
    logic          cap_ed_q;
    logic [63:0]   rsp_s1_q, rsp_s2_q;
    logic          rsp_id_q, rsp_err_q;

    always_comb begin
        grant = bus.req_valid[1];
        if (bus.req_valid == 2'b11) grant = ~last_grant_q;
    end

    always_comb begin
        state_d   = state_q;
        take      = 1'b0;
        done_ok   = 1'b0;
        timed_out = 1'b0;
        case (state_q)
            // rst gating keeps req_ready low while reset is asserted
            IDLE: if (rst && (|bus.req_valid)) begin
                take    = 1'b1;
                state_d = LOAD;
            end
            LOAD: if (cnt_q == LOAD_LAST) state_d = RUN;
            RUN: begin
                if (bus.core_done) begin
                    done_ok = 1'b1;
                    state_d = OUT;
                end else if (cnt_q == RUN_LAST) begin
                    timed_out = 1'b1;
                    state_d   = OUT;
                end
            end
            OUT: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            cap_s1_q     <= '0;
            cap_s2_q     <= '0;
            cap_key_q    <= '0;
            cap_ed_q     <= 1'b0;
            rsp_s1_q     <= '0;
            rsp_s2_q     <= '0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                cnt_q <= '0;
            else if (state_q == LOAD || state_q == RUN)
                cnt_q <= cnt_q + 32'd1;

            if (take) begin
                last_grant_q <= grant;
                rsp_id_q     <= grant;
                cap_s1_q     <= grant ? bus.req_s1[127:64]   : bus.req_s1[63:0];
                cap_s2_q     <= grant ? bus.req_s2[127:64]   : bus.req_s2[63:0];
                cap_key_q    <= grant ? bus.req_key[255:128] : bus.req_key[127:0];
                cap_ed_q     <= grant ? bus.req_enc_dec[1]   : bus.req_enc_dec[0];
            end

            if (done_ok) begin
                rsp_s1_q  <= bus.core_out_s1;
                rsp_s2_q  <= bus.core_out_s2;
                rsp_err_q <= 1'b0;
            end else if (timed_out) begin
                rsp_s1_q  <= '0;
                rsp_s2_q  <= '0;
                rsp_err_q <= 1'b1;
            end
        end
    end

    assign bus.req_ready    = take ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign bus.core_rst     = (state_q != RUN);
    assign bus.core_s1      = cap_s1_q;
    assign bus.core_s2      = cap_s2_q;
    assign bus.core_key     = cap_key_q;
    assign bus.core_enc_dec = cap_ed_q;
    assign bus.rsp_valid    = (state_q == OUT);
    assign bus.rsp_s1       = rsp_s1_q;
    assign bus.rsp_s2       = rsp_s2_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_err      = rsp_err_q;
endmodule
